// File: rtl/slave_route_tracker_pkg.sv
// Crossbar-wide shared constants for the per-master slave route tracker.
// Optional feature macro used by this slice: ROUTER_TIMEOUT_EN.
package slave_route_tracker_pkg;

   localparam int unsigned NS_DEFAULT         = 8;
   localparam int unsigned AW_DEFAULT         = 32;
   localparam int unsigned DW_DEFAULT         = 70;
   localparam int unsigned LGMAXBURST_DEFAULT = 4;
   localparam int unsigned TIMEOUT_DEFAULT    = 1023;

   // Decode bit that flags "no slave matched" for the default crossbar size
   localparam int unsigned NONE_SLAVE = NS_DEFAULT;

   // Index of the "no slave" decode bit for an arbitrary slave count
   function automatic int unsigned none_slave_idx(input int unsigned ns);
      return ns;
   endfunction

endpackage

// File: rtl/slave_route_tracker_outstanding_ctr.sv
// Outstanding-transaction up/down counter with empty/full flags.
// With ROUTER_TIMEOUT_EN defined, a response watchdog aborts a stuck burst.
module route_outstanding_ctr
   import slave_route_tracker_pkg::*;
#(
   parameter int unsigned LGMAXBURST = LGMAXBURST_DEFAULT,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_empty_c,
   output logic o_full_c,
   output logic o_timeout_c,
   output logic o_busy
);

   localparam int unsigned CW = LGMAXBURST + 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;

   assign o_empty_c = (cnt_q == '0);
   assign o_full_c  = (cnt_q == CW'(2 ** LGMAXBURST));
   assign o_busy    = busy_q;

`ifdef ROUTER_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] tmo_q, tmo_d;
   logic          timeout_c;

   // Fires on the cycle the idle-response count reaches TIMEOUT
   assign timeout_c   = !o_empty_c && (tmo_q == TW'(TIMEOUT - 1));
   assign o_timeout_c = timeout_c;

   // Watchdog restarts whenever anything comes back or nothing is pending
   always_comb begin
      tmo_d = tmo_q + TW'(1);
      if (i_clear || i_dec || o_empty_c || timeout_c) begin
         tmo_d = '0;
      end
   end

   // Watchdog register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   localparam int unsigned unused_timeout = TIMEOUT;
   assign o_timeout_c = 1'b0;
`endif

   // Next outstanding count; accept and response in one cycle cancel out
   always_comb begin
      cnt_d = cnt_q + CW'(i_inc) - CW'(i_dec);
      if (i_clear || o_timeout_c) begin
         cnt_d = '0;
      end
      busy_d = (cnt_d != '0);
   end

   // Count and busy registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/slave_route_tracker.sv
// Per-master route tracker behind the crossbar address decoder: steers each
// request to one slave, keeps responses in order, and synthesises a bus error
// for requests that decode to no slave.
// Optional feature macro: ROUTER_TIMEOUT_EN (response watchdog).
module slave_route_tracker
   import slave_route_tracker_pkg::*;
#(
   parameter int unsigned NS         = NS_DEFAULT,
   parameter int unsigned AW         = AW_DEFAULT,
   parameter int unsigned DW         = DW_DEFAULT,
   parameter int unsigned LGMAXBURST = LGMAXBURST_DEFAULT,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_abort,
   input  logic          i_valid,
   output logic          o_stall,
   input  logic [NS:0]   i_decode,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_data,
   output logic [NS-1:0] o_slv_valid,
   input  logic [NS-1:0] i_slv_stall,
   output logic [AW-1:0] o_slv_addr,
   output logic [DW-1:0] o_slv_data,
   input  logic [NS-1:0] i_slv_ack,
   input  logic [NS-1:0] i_slv_err,
   output logic          o_ack,
   output logic          o_err,
   output logic          o_busy
);

   localparam int unsigned NONE = none_slave_idx(NS);

   logic [NS:0] sel_q, sel_d;
   logic        none_err_q, none_err_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;

   logic kill_c, blocked_c, accept_c;
   logic ack_sel_c, err_sel_c, dec_c;
   logic empty_c, full_c, timeout_c;

   assign o_slv_addr = i_addr;
   assign o_slv_data = i_data;
   assign o_ack      = ack_q;
   assign o_err      = err_q;

   // Request gating, slave strobes and response selection
   always_comb begin
      kill_c    = i_reset || i_abort;
      blocked_c = (!empty_c && (i_decode != sel_q)) || full_c
                  || (i_decode == '0) || timeout_c;
      o_stall   = i_valid && (blocked_c || (|(i_decode[NS-1:0] & i_slv_stall)));
      o_slv_valid = '0;
      if (i_valid && !blocked_c && !kill_c) begin
         o_slv_valid = i_decode[NS-1:0];
      end
      accept_c  = i_valid && !o_stall && !kill_c;
      ack_sel_c = !empty_c && (|(i_slv_ack & sel_q[NS-1:0]));
      err_sel_c = !empty_c && (|(i_slv_err & sel_q[NS-1:0]));
      dec_c     = ack_sel_c || err_sel_c || none_err_q;
   end

   // Next target, pending none-error and master response
   always_comb begin
      sel_d      = sel_q;
      none_err_d = 1'b0;
      ack_d      = 1'b0;
      err_d      = 1'b0;
      if (!kill_c) begin
         if (accept_c) begin
            sel_d      = i_decode;
            none_err_d = i_decode[NONE];
         end
         if (timeout_c) begin
            sel_d      = '0;
            none_err_d = 1'b0;
         end
         ack_d = ack_sel_c && !err_sel_c;
         err_d = err_sel_c || none_err_q || timeout_c;
      end else begin
         sel_d = '0;
      end
   end

   // Route state registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sel_q      <= '0;
         none_err_q <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         sel_q      <= sel_d;
         none_err_q <= none_err_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
      end
   end

   route_outstanding_ctr #(
      .LGMAXBURST (LGMAXBURST),
      .TIMEOUT    (TIMEOUT)
   ) u_ctr (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_clear     (i_abort),
      .i_inc       (accept_c),
      .i_dec       (dec_c),
      .o_empty_c   (empty_c),
      .o_full_c    (full_c),
      .o_timeout_c (timeout_c),
      .o_busy      (o_busy)
   );

endmodule
